// File: rtl/reply_sender.sv
// reply_sender: frames reply requests and error reports into bytes for the proto245 TX FIFO.
// Define REPLY_CHECKSUM_EN to append an XOR checksum byte (6-byte frames instead of 5).
module reply_sender #(
  parameter int         DATA_W         = 8,
  parameter int         TX_FIFO_LOAD_W = 10,
  parameter int         TX_FIFO_SIZE   = 512,
  parameter logic [7:0] ERR_OPCODE     = 8'hEE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_opcode,
  input  logic [31:0]               req_payload,
  input  logic                      err_pulse,
  output logic                      busy,
  output logic [31:0]               err_count,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  input  logic                      txfifo_full,
  output logic                      txfifo_wr,
  output logic [DATA_W-1:0]         txfifo_data
);

`ifdef REPLY_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  localparam logic [TX_FIFO_LOAD_W:0] SPACE_LIMIT = (TX_FIFO_LOAD_W+1)'(TX_FIFO_SIZE - FRAME_LEN);
  localparam logic [2:0]              LAST_IDX    = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t            state;
  logic              run;
  logic              err_pending;
  logic              err_latch;
  logic [7:0]        opcode_q;
  logic [31:0]       payload_q;
  logic [2:0]        idx;
  logic [DATA_W-1:0] cur_byte;

  // An error pulse in the same cycle blocks acceptance so the error frame goes first.
  assign req_ready = run && (state == IDLE) && !err_pending && !err_pulse;
  assign busy      = (state != IDLE);
  assign err_latch = (state == IDLE) && err_pending;

  always_comb begin
    cur_byte = opcode_q;
    case (idx)
      3'd1:    cur_byte = payload_q[31:24];
      3'd2:    cur_byte = payload_q[23:16];
      3'd3:    cur_byte = payload_q[15:8];
      3'd4:    cur_byte = payload_q[7:0];
`ifdef REPLY_CHECKSUM_EN
      3'd5:    cur_byte = opcode_q ^ payload_q[31:24] ^ payload_q[23:16]
                          ^ payload_q[15:8] ^ payload_q[7:0];
`endif
      default: cur_byte = opcode_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      err_pending <= 1'b0;
      err_count   <= '0;
      opcode_q    <= '0;
      payload_q   <= '0;
      idx         <= '0;
      txfifo_wr   <= 1'b0;
      txfifo_data <= '0;
    end else begin
      run       <= 1'b1;
      txfifo_wr <= 1'b0;
      if (err_pulse && (err_count != '1))
        err_count <= err_count + 32'd1;
      // A pulse coinciding with the latch keeps the flag set for a follow-up frame.
      err_pending <= err_pulse || (err_pending && !err_latch);

      case (state)
        IDLE: begin
          if (err_pending) begin
            opcode_q  <= ERR_OPCODE;
            payload_q <= err_count;
            state     <= WAIT;
          end else if (req_valid && req_ready) begin
            opcode_q  <= req_opcode;
            payload_q <= req_payload;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if ({1'b0, txfifo_load} <= SPACE_LIMIT) begin
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (!txfifo_full) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= cur_byte;
            if (idx == LAST_IDX)
              state <= IDLE;
            else
              idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reply_sender.sv
// Self-checking bench for reply_sender: directed vector table, corner sequences and a random run
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_reply_sender;

`ifdef REPLY_CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif
  localparam int FIFO_SIZE = 512;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        req_valid   = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode  = '0;
  logic [31:0] req_payload = '0;
  logic        err_pulse   = 1'b0;
  logic        busy;
  logic [31:0] err_count;
  logic [9:0]  txfifo_load = '0;
  logic        txfifo_full = 1'b0;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  logic [7:0]  exp_q[$];
  logic [31:0] mdl_cnt = '0;

  typedef struct {
    logic [9:0]  load;
    logic [7:0]  op;
    logic [31:0] pl;
    bit          starts;
  } gate_vec_t;

  reply_sender #(
    .DATA_W(8), .TX_FIFO_LOAD_W(10), .TX_FIFO_SIZE(FIFO_SIZE), .ERR_OPCODE(8'hEE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_payload(req_payload), .err_pulse(err_pulse),
    .busy(busy), .err_count(err_count), .txfifo_load(txfifo_load),
    .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr), .txfifo_data(txfifo_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && txfifo_wr) begin
      got_q.push_back(txfifo_data);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [31:0] pl);
    logic [7:0] b[5];
    logic [7:0] x;
    x = '0;
    b[0] = op;
    for (int i = 1; i < 5; i++) b[i] = 8'(pl >> (8 * (4 - i)));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(b[i]);
      x ^= b[i];
    end
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic do_req(input logic [7:0] op, input logic [31:0] pl, input bit with_err,
                        output int unsigned acc);
    bit done;
    done = 1'b0;
    acc = 0;
    req_opcode = op; req_payload = pl; req_valid = 1'b1; err_pulse = with_err;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      step();
      err_pulse = 1'b0;
      if (done) acc = cyc;
    end
    req_valid = 1'b0;
    err_pulse = 1'b0;
    check("req_accept", done, 1);
  endtask

  task automatic drain(input string name, input int unsigned budget, output int unsigned first_t);
    for (int unsigned i = 0; i < budget && got_q.size() < exp_q.size(); i++) step();
    repeat (FL + 3) step();
    check({name, "_len"}, got_q.size(), exp_q.size());
    first_t = (got_t.size() != 0) ? got_t[0] : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; err_pulse = 1'b0; txfifo_full = 1'b0; txfifo_load = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    got_q.delete(); got_t.delete(); exp_q.delete();
    mdl_cnt = '0;
  endtask

  initial begin
    gate_vec_t   gv[7];
    int unsigned acc, t0, c, idle_cycles;
    logic [39:0] req_mq[$];
    logic [39:0] head;
    logic [7:0]  op, x;
    logic [31:0] pl, last_err;
    bit          accepted;

    // reset state
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", txfifo_wr, 0);
    check("rst_data", txfifo_data, 0);
    check("rst_err_count", err_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("idle_req_ready", req_ready, 1);
    check("idle_busy", busy, 0);

    // single reply and latency
    do_req(8'h12, 32'hDEAD_BEEF, 1'b0, acc);
    push_frame(8'h12, 32'hDEAD_BEEF);
    drain("single", 20, t0);
    check("single_latency", t0 - acc, 2);

    // space gating table
    gv[0] = '{10'd0,    8'h21, 32'hA5A5_0001, 1'b0};
    gv[1] = '{10'd505,  8'h22, 32'h0102_0304, 1'b0};
    gv[2] = '{10'd506,  8'h23, 32'hFFFF_0000, 1'b0};
    gv[3] = '{10'd507,  8'h24, 32'h8000_0001, 1'b0};
    gv[4] = '{10'd508,  8'h25, 32'h5A5A_5A5A, 1'b0};
    gv[5] = '{10'd511,  8'h26, 32'h0000_00FF, 1'b0};
    gv[6] = '{10'd1023, 8'h27, 32'h1357_9BDF, 1'b0};
    foreach (gv[k]) gv[k].starts = (int'(gv[k].load) + FL <= FIFO_SIZE);
    foreach (gv[k]) begin
      txfifo_load = gv[k].load;
      do_req(gv[k].op, gv[k].pl, 1'b0, acc);
      repeat (8) step();
      check($sformatf("gate%0d_started", k), got_q.size() != 0, gv[k].starts);
      c = cyc;
      if (got_q.size() == 0) txfifo_load = 10'(FIFO_SIZE - FL);
      push_frame(gv[k].op, gv[k].pl);
      drain($sformatf("gate%0d", k), 20, t0);
      if (!gv[k].starts) check($sformatf("gate%0d_resume", k), t0, c + 2);
      txfifo_load = '0;
    end

    // error and request in the same idle cycle
    do_req(8'h34, 32'h0102_0304, 1'b1, acc);
    check("prio_err_count", err_count, 1);
    push_frame(8'hEE, 32'd1);
    push_frame(8'h34, 32'h0102_0304);
    drain("prio", 40, t0);

    // asynchronous reset in the middle of a frame
    do_req(8'h77, 32'h1234_5678, 1'b0, acc);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr", txfifo_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_req_ready", req_ready, 0);
    check("rst_mid_err_count", err_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_mid_release_ready", req_ready, 1);
    got_q.delete(); got_t.delete(); exp_q.delete();

    // error arriving mid-frame
    do_req(8'h56, 32'hCAFE_F00D, 1'b0, acc);
    for (int i = 0; i < 20 && got_q.size() < 3; i++) step();
    err_pulse = 1'b1;
    step();
    err_pulse = 1'b0;
    push_frame(8'h56, 32'hCAFE_F00D);
    push_frame(8'hEE, 32'd1);
    idle_cycles = 0;
    for (int i = 0; i < 40 && got_q.size() < 2 * FL; i++) begin
      if (!busy) idle_cycles++;
      step();
    end
    check("midframe_idle_gap", idle_cycles, 1);
    drain("midframe", 10, t0);

    // counter saturation
    @(negedge clk);
    force dut.err_count = 32'hFFFF_FFFF;
    #1 release dut.err_count;
    step();
    check("sat_preload", err_count, 32'hFFFF_FFFF);
    err_pulse = 1'b1;
    step();
    err_pulse = 1'b0;
    check("sat_hold", err_count, 32'hFFFF_FFFF);
    push_frame(8'hEE, 32'hFFFF_FFFF);
    drain("sat_frame", 30, t0);

    // FIFO-full stall mid-frame
    do_req(8'h9A, 32'h1122_3344, 1'b0, acc);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) step();
    txfifo_full = 1'b1;
    step();
    c = got_q.size();
    repeat (4) begin
      check("stall_no_wr", txfifo_wr, 0);
      step();
    end
    check("stall_held", got_q.size(), c);
    check("stall_busy", busy, 1);
    txfifo_full = 1'b0;
    push_frame(8'h9A, 32'h1122_3344);
    drain("stall", 20, t0);

    // randomized run against the frame-level model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      check("rnd_err_count", err_count, mdl_cnt);
      accepted  = 1'b0;
      err_pulse = ($urandom_range(0, 11) == 0);
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        do req_opcode = 8'($urandom()); while (req_opcode == 8'hEE);
        req_payload = $urandom();
        req_valid   = 1'b1;
      end
      txfifo_load = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(500, 1023))
                                                : 10'($urandom_range(0, 400));
      #1;
      if (req_valid && req_ready) begin
        req_mq.push_back({req_opcode, req_payload});
        accepted = 1'b1;
      end
      if (err_pulse && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
      step();
      if (accepted) req_valid = 1'b0;
    end
    err_pulse = 1'b0; req_valid = 1'b0; txfifo_load = '0;
    repeat (60) step();
    check("rnd_err_count_end", err_count, mdl_cnt);
    check("rnd_len_mod", got_q.size() % FL, 0);
    last_err = '0;
    for (int f = 0; f + FL <= got_q.size(); f += FL) begin
      op = got_q[f];
      pl = {got_q[f+1], got_q[f+2], got_q[f+3], got_q[f+4]};
`ifdef REPLY_CHECKSUM_EN
      x = op ^ got_q[f+1] ^ got_q[f+2] ^ got_q[f+3] ^ got_q[f+4];
      check("rnd_checksum", got_q[f+5], x);
`endif
      if (op == 8'hEE) begin
        check("rnd_err_increasing", pl > last_err, 1);
        check("rnd_err_bounded", pl <= mdl_cnt, 1);
        last_err = pl;
      end else begin
        check("rnd_req_expected", req_mq.size() != 0, 1);
        if (req_mq.size() != 0) begin
          head = req_mq.pop_front();
          check("rnd_req_frame", {op, pl}, head);
        end
      end
    end
    check("rnd_req_left", req_mq.size(), 0);
    check("rnd_last_err", last_err, mdl_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
